weight_pattern_gen: RTL and testbench



---
 rtl/weight_pattern_gen_pkg.sv | 21 ++
 rtl/weight_pattern_gen_gosper.sv | 33 +++
 rtl/weight_pattern_gen.sv | 101 ++++++++++
 tb/tb_weight_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pattern_gen_pkg.sv
// Shared definitions for the weight pattern generator: FSM states and
// closed-form first/last words of a fixed-popcount sweep.
package weight_pattern_gen_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // k ones packed at the LSB end; a shift of MAX_WIDTH or more yields zero, so k=MAX_WIDTH works
    function automatic logic [MAX_WIDTH-1:0] first_word(input int unsigned k);
        return ~({MAX_WIDTH{1'b1}} << k);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] last_word(input int unsigned k, input int unsigned width);
        return first_word(k) << (width - k);
    endfunction

endpackage

// File: rtl/weight_pattern_gen_gosper.sv
// Combinational Gosper step: next larger word with the same popcount as c_i.
// The divide of the classic formulation is replaced by a shift of tz(lowBit)+2.
module gosper_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] next_o
);

    localparam int TZW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0] lowBit;
    logic [WIDTH:0]   ripple;
    logic [WIDTH:0]   changed;
    logic [TZW-1:0]   tz;

    assign lowBit  = c_i & (~c_i + 1'b1);
    assign ripple  = {1'b0, c_i} + {1'b0, lowBit};
    assign changed = {1'b0, c_i} ^ ripple;

    // Priority encoder: the last assignment wins, leaving the lowest set bit position
    always_comb begin
        tz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (lowBit[i]) begin
                tz = TZW'(i);
            end
        end
    end

    assign next_o = WIDTH'(ripple | (changed >> (tz + TZW'(2))));

endmodule

// File: rtl/weight_pattern_gen.sv
// Streams every WIDTH-bit word of popcount k in increasing order over a
// valid/ready handshake, one word per accepted beat.
module weight_pattern_gen
    import weight_pattern_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(WIDTH+1)-1:0]   weight,
    input  logic                         abort,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_word,
    output logic [IDXW-1:0]              out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         err
);

    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] MAX_K = KW'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [IDXW-1:0]  index_q;
    logic [KW-1:0]    k_q;
    logic             valid_q;
    logic             err_q;

    logic [WIDTH-1:0] nextWord_d;
    logic [WIDTH-1:0] firstWord_d;
    logic [WIDTH-1:0] lastWord_d;
    logic             isLast;

    gosper_next #(.WIDTH(WIDTH)) u_gosper (
        .c_i    (word_q),
        .next_o (nextWord_d)
    );

    assign firstWord_d = WIDTH'(first_word(32'(weight)));
    assign lastWord_d  = WIDTH'(last_word(32'(k_q), WIDTH));
    assign isLast      = (word_q == lastWord_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            index_q <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (weight <= MAX_K) begin
                            k_q     <= weight;
                            word_q  <= firstWord_d;
                            index_q <= '0;
                            valid_q <= 1'b1;
                            state_q <= EMIT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Abort wins over a same-cycle ready, so that beat is dropped
                    if (abort) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (out_ready) begin
                        if (isLast) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            word_q  <= nextWord_d;
                            index_q <= index_q + 1'b1;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_index = index_q;
    assign out_last  = valid_q && isLast;
    assign busy      = (state_q == EMIT);
    assign err       = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Self-checking bench: a list-based model of each sweep is compared against
// the DUT every cycle, with directed scenarios pinning literal words.
module tb_weight_pattern_gen;

    localparam int WIDTH = 8;
    localparam int IDXW  = 7;
    localparam int KW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [KW-1:0]    weight = '0;
    logic             abort = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_word;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             busy;
    logic             err;

    int vectorCount = 0;
    int miscompareCount = 0;
    bit checkEnable = 0;

    logic [WIDTH-1:0] modelList[$];
    bit mActive = 0;
    bit mErr = 0;
    int mIdx = 0;
    int mK = 0;

    weight_pattern_gen #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .weight    (weight),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [KW-1:0] w, input logic rdy, input logic ab);
        start     = s;
        weight    = w;
        out_ready = rdy;
        abort     = ab;
        @(posedge clk);
        #1;
    endtask

    // Every WIDTH-bit value with popcount k, ascending
    function automatic void buildList(input int k);
        modelList.delete();
        for (int v = 0; v < (1 << WIDTH); v++) begin
            if ($countones(v) == k) begin
                modelList.push_back(WIDTH'(v));
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mActive = 0;
            mErr    = 0;
            mIdx    = 0;
        end else begin
            mErr = 0;
            if (!mActive) begin
                if (start) begin
                    if (int'(weight) <= WIDTH) begin
                        mK = int'(weight);
                        buildList(mK);
                        mIdx    = 0;
                        mActive = 1;
                    end else begin
                        mErr = 1;
                    end
                end
            end else if (abort) begin
                mActive = 0;
            end else if (out_ready) begin
                if (mIdx == modelList.size() - 1) begin
                    mActive = 0;
                end else begin
                    mIdx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("out_valid", 32'(out_valid), 32'(mActive));
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("out_last", 32'(out_last), 32'(mActive && (mIdx == modelList.size() - 1)));
            if (mActive) begin
                checkOutput("out_word", 32'(out_word), 32'(modelList[mIdx]));
                checkOutput("out_index", 32'(out_index), 32'(mIdx));
                checkOutput("popcount", 32'($countones(out_word)), 32'(mK));
            end
        end
    end

    task automatic runToIdle(input int budget);
        int n = 0;
        while (out_valid === 1'b1 && n < budget) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        vectorCount++;
        if (n >= budget) begin
            miscompareCount++;
            $display("[TB] FAIL sweepTimeout: got %0d cycles, expected fewer than %0d", n, budget);
        end
    endtask

    task automatic checkResetValues(input string tag);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_word"}, 32'(out_word), 32'd0);
        checkOutput({tag, "_index"}, 32'(out_index), 32'd0);
        checkOutput({tag, "_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w2Words [0:4];
        int               w2Index [0:4];
        int               cycles;
        w2Words = '{8'h03, 8'h05, 8'h06, 8'h09, 8'hC0};
        w2Index = '{0, 1, 2, 3, 27};

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        checkResetValues("reset");
        checkEnable = 1;

        $display("[TB] weight=2 full sweep");
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
        checkOutput("model_w2_size", 32'(modelList.size()), 32'd28);
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++) begin
                if (w2Index[p] == i) begin
                    checkOutput("w2_word", 32'(out_word), 32'(w2Words[p]));
                end
            end
            checkOutput("w2_last", 32'(out_last), 32'(i == 27));
            applyStimulus(1'b0, 4'd2, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("w2_done_valid", 32'(out_valid), 32'd0);
        checkOutput("w2_done_busy", 32'(busy), 32'd0);

        $display("[TB] weight=0 and weight=8 single beats");
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w0_word", 32'(out_word), 32'h00);
        checkOutput("w0_last", 32'(out_last), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w8_word", 32'(out_word), 32'hFF);
        checkOutput("w8_last", 32'(out_last), 32'd1);
        checkOutput("w8_index", 32'(out_index), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] weight=9 error pulse");
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w9_err", 32'(err), 32'd1);
        checkOutput("w9_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w9_err_clear", 32'(err), 32'd0);
        checkOutput("w9_busy", 32'(busy), 32'd0);

        $display("[TB] weight=4 with stall on 0x1D");
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
        checkOutput("model_w4_size", 32'(modelList.size()), 32'd70);
        repeat (3) applyStimulus(1'b0, 4'd4, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("w4_stall_word", 32'(out_word), 32'h1D);
            checkOutput("w4_stall_index", 32'(out_index), 32'd3);
            applyStimulus(1'b0, 4'd4, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("w4_held_word", 32'(out_word), 32'h1D);
        runToIdle(100);

        $display("[TB] weight=3 abort at index 10, then weight=1");
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 4'd3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w3_index", 32'(out_index), 32'd10);
        applyStimulus(1'b0, 4'd3, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("w3_abort_valid", 32'(out_valid), 32'd0);
        checkOutput("w3_abort_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("w1_word", 32'(out_word), 32'(1 << i));
            checkOutput("w1_last", 32'(out_last), 32'(i == 7));
            applyStimulus(1'b0, 4'd1, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("w1_done_valid", 32'(out_valid), 32'd0);

        $display("[TB] reset during weight=5 sweep");
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        repeat (7) applyStimulus(1'b0, 4'd5, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w5_index", 32'(out_index), 32'd7);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b0;
        checkResetValues("midreset");
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("w5_restart_word", 32'(out_word), 32'h1F);
        checkOutput("w5_restart_index", 32'(out_index), 32'd0);
        runToIdle(100);

        $display("[TB] randomized sweeps");
        for (int s = 0; s < 40; s++) begin
            applyStimulus(1'b1, KW'($urandom_range(0, 11)), 1'b1, 1'b0);
            cycles = 0;
            while (out_valid === 1'b1 && cycles < 400) begin
                applyStimulus($urandom_range(0, 7) == 0, KW'($urandom_range(0, 15)),
                              $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
                cycles++;
            end
            vectorCount++;
            if (cycles >= 400) begin
                miscompareCount++;
                $display("[TB] FAIL randomTimeout: got %0d cycles, expected fewer than 400", cycles);
            end
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
